dram_cmd_sequencer: RTL and testbench
=====================================

# dram_cmd_sequencer

Per-bank command sequencer between the request scheduler and the DRAM command bus. It accepts one decoded request at a time and tracks the open row of every bank. It expands each request into the PRECHARGE / ACTIVATE / READ / WRITE commands it needs, enforcing precharge and activation latencies. It also issues periodic REFRESH commands, which close all banks.

## Interface
- BANK_GROUPS, 8, number of bank groups
- BANKS_PER_GROUP, 8, banks per group; BANKS = BANK_GROUPS*BANKS_PER_GROUP
- ROW_BITS, 8, row address width
- COL_BITS, 4, column address width
- ACTIVATION_LATENCY, 8, cycles from ACT handshake to first READ/WRITE (≥1)
- PRECHARGE_LATENCY, 5, cycles from PRE handshake to ACT (≥1)
- REFRESH_INTERVAL, 1024, cycles between refresh requests (≥2)
- REFRESH_LATENCY, 32, cycles from REF handshake until a new command may issue (≥1)

Ports:
- clk_in  in  1  clock; all state updates on the rising edge
- rst_in  in  1  asynchronous, active-high reset
- req_valid_in  in  1  request present
- req_ready_out  out  1  sequencer can accept a request
- req_write_in  in  1  1 = write, 0 = read
- bank_group_in  in  clog2(BANK_GROUPS)  target bank group
- bank_in  in  clog2(BANKS_PER_GROUP)  target bank
- row_in  in  ROW_BITS  target row
- col_in  in  COL_BITS  target column
- val_in  in  512  write data
- cmd_ready_in  in  1  command bus accepts command this cycle
- valid_out  out  1  command valid
- cmd_out  out  3  0 NOP, 1 ACT, 2 READ, 3 WRITE, 4 PRE, 5 REF
- bank_group_out, bank_out, row_out, col_out  out  same widths as inputs  command address
- val_out  out  512  write data for a WRITE command
- refresh_pending_out  out  1  refresh is owed

## Operation
- Open-row table: BANKS entries of {open, row}. Reset clears every open bit.
- States: IDLE, PRE, PRE_WAIT, ACT, ACT_WAIT, RW, REF, REF_WAIT.
- req_ready_out = (state==IDLE) && !refresh_pending. Accept on the edge where req_valid_in && req_ready_out. All request fields are captured at accept.
- Routing at accept:
  - open && row match (hit) → RW
  - open && row mismatch → PRE
  - closed → ACT
- PRE, ACT, RW, REF drive valid_out=1 with the matching cmd_out and the captured address. A command completes on an edge where cmd_ready_in=1.
- Completion actions:
  - PRE → PRE_WAIT; clears the bank's open bit
  - ACT → ACT_WAIT; sets open and row
  - RW → IDLE
  - REF → REF_WAIT; clears all open bits
- Wait states: PRE_WAIT → ACT, ACT_WAIT → RW, REF_WAIT → IDLE, after the latencies below.
- Refresh: a free-running counter runs every cycle in every state and wraps at REFRESH_INTERVAL-1. Each wrap sets refresh_pending. A wrap while already pending is absorbed (no queuing). The REF handshake clears refresh_pending.
- Refresh priority:
  - An in-flight request always completes first.
  - In IDLE with refresh pending, go to REF; no request is accepted.
  - If a wrap and an accept fall on the same edge, the accept wins and refresh follows that request.
- REF addresses: row_out, col_out, bank_group_out and bank_out are 0.
- Outputs when valid_out=0: cmd_out=NOP. Address and data outputs hold their last values.

## Timing
- Reset values (asserted immediately, asynchronously): state IDLE, valid_out 0, cmd_out 0, all address outputs and val_out 0, refresh_pending_out 0, refresh counter 0, table cleared. req_ready_out=1 while in reset.
- The first command is visible in the cycle after the accept edge. The accept-to-command latency is therefore 1 cycle.
- With the handshake at edge E, the next command's valid_out rises after edge E+L:
  - L = PRECHARGE_LATENCY for PRE→ACT
  - L = ACTIVATION_LATENCY for ACT→RW
  - L = REFRESH_LATENCY for REF→IDLE
- Latencies count from the handshake edge, never from the first assertion of valid_out.
- Stall: while valid_out=1 and cmd_ready_in=0, every output holds stable.
- After the RW handshake, req_ready_out is 1 in the next cycle, unless refresh is pending.
- Reset mid-operation aborts any command. The next request to any bank sees it as closed and issues ACT with no PRE.

## Test plan
- Reset; write bg3/b2 row 0x55 col 0xA val 0xA5A5A5A5A5A5A5A5, cmd_ready_in=1 → ACT(3,2,0x55) in the cycle after accept; WRITE(col 0xA, val_out A5..) rises exactly 8 cycles after the ACT handshake; req_ready_out high the following cycle.
- Read bg3/b2 row 0x55 col 0x1 → single READ one cycle after accept, no ACT.
- Read bg3/b2 row 0x0F col 0x8 → PRE; ACT(row 0x0F) 5 cycles after the PRE handshake; READ 8 cycles after the ACT handshake.
- Hold cmd_ready_in=0 for 4 cycles during ACT → outputs stable for all 4 cycles; WRITE still issues 8 cycles after the eventual handshake.
- REFRESH_INTERVAL=64 with a miss in flight at the wrap → request completes; REF issues next; req_ready_out=0 until REF_WAIT ends (32 cycles); the next access to the previously open row issues ACT.
- Assert rst_in during PRE_WAIT → valid_out=0 and cmd_out=0 immediately; after release, a request to that bank issues ACT with no PRE.

Source files
------------

// File: rtl/dram_cmd_sequencer.sv
// Per-bank DRAM command sequencer: expands requests into PRE/ACT/RD/WR,
// tracks open rows, and injects periodic REFRESH.
module dram_cmd_sequencer #(
  parameter int BANK_GROUPS        = 8,
  parameter int BANKS_PER_GROUP    = 8,
  parameter int ROW_BITS           = 8,
  parameter int COL_BITS           = 4,
  parameter int ACTIVATION_LATENCY = 8,
  parameter int PRECHARGE_LATENCY  = 5,
  parameter int REFRESH_INTERVAL   = 1024,
  parameter int REFRESH_LATENCY    = 32
) (
  input  logic                               clk_in,
  input  logic                               rst_in,
  input  logic                               req_valid_in,
  output logic                               req_ready_out,
  input  logic                               req_write_in,
  input  logic [$clog2(BANK_GROUPS)-1:0]     bank_group_in,
  input  logic [$clog2(BANKS_PER_GROUP)-1:0] bank_in,
  input  logic [ROW_BITS-1:0]                row_in,
  input  logic [COL_BITS-1:0]                col_in,
  input  logic [511:0]                       val_in,
  input  logic                               cmd_ready_in,
  output logic                               valid_out,
  output logic [2:0]                         cmd_out,
  output logic [$clog2(BANK_GROUPS)-1:0]     bank_group_out,
  output logic [$clog2(BANKS_PER_GROUP)-1:0] bank_out,
  output logic [ROW_BITS-1:0]                row_out,
  output logic [COL_BITS-1:0]                col_out,
  output logic [511:0]                       val_out,
  output logic                               refresh_pending_out
);

  localparam int BANKS = BANK_GROUPS * BANKS_PER_GROUP;
  localparam int IW    = $clog2(BANKS);
  localparam int RCW   = $clog2(REFRESH_INTERVAL);
  localparam int WW    = 16;

  localparam logic [2:0] C_NOP = 3'd0;
  localparam logic [2:0] C_ACT = 3'd1;
  localparam logic [2:0] C_RD  = 3'd2;
  localparam logic [2:0] C_WR  = 3'd3;
  localparam logic [2:0] C_PRE = 3'd4;
  localparam logic [2:0] C_REF = 3'd5;

  typedef enum logic [2:0] {
    IDLE, PRE, PRE_WAIT, ACT, ACT_WAIT, RW, REF, REF_WAIT
  } state_t;

  state_t               state, state_nxt;
  logic [WW-1:0]        wait_cnt, wait_nxt;
  logic [RCW-1:0]       ref_cnt;
  logic                 pending;
  logic                 write_q;
  logic [BANKS-1:0]     open_q;
  logic [ROW_BITS-1:0]  row_tab [BANKS];
  logic [IW-1:0]        idx_in, idx_q;
  logic                 accept, hit, wrap, done;

  assign idx_in = {bank_group_in, bank_in};
  assign idx_q  = {bank_group_out, bank_out};
  assign req_ready_out = (state == IDLE) && !pending;
  assign accept = req_valid_in && req_ready_out;
  assign hit    = open_q[idx_in] && (row_tab[idx_in] == row_in);
  assign wrap   = (ref_cnt == RCW'(REFRESH_INTERVAL - 1));
  assign done   = valid_out && cmd_ready_in;
  assign refresh_pending_out = pending;

  always_comb begin
    state_nxt = state;
    wait_nxt  = wait_cnt;
    valid_out = 1'b0;
    cmd_out   = C_NOP;
    unique case (state)
      IDLE: begin
        if (pending)
          state_nxt = REF;
        else if (req_valid_in)
          state_nxt = hit ? RW : (open_q[idx_in] ? PRE : ACT);
      end
      PRE: begin
        valid_out = 1'b1;
        cmd_out   = C_PRE;
        if (cmd_ready_in) begin
          state_nxt = PRE_WAIT;
          wait_nxt  = WW'(PRECHARGE_LATENCY - 1);
        end
      end
      PRE_WAIT: begin
        if (wait_cnt == '0) state_nxt = ACT;
        else wait_nxt = wait_cnt - 1'b1;
      end
      ACT: begin
        valid_out = 1'b1;
        cmd_out   = C_ACT;
        if (cmd_ready_in) begin
          state_nxt = ACT_WAIT;
          wait_nxt  = WW'(ACTIVATION_LATENCY - 1);
        end
      end
      ACT_WAIT: begin
        if (wait_cnt == '0) state_nxt = RW;
        else wait_nxt = wait_cnt - 1'b1;
      end
      RW: begin
        valid_out = 1'b1;
        cmd_out   = write_q ? C_WR : C_RD;
        if (cmd_ready_in) state_nxt = IDLE;
      end
      REF: begin
        valid_out = 1'b1;
        cmd_out   = C_REF;
        if (cmd_ready_in) begin
          state_nxt = REF_WAIT;
          wait_nxt  = WW'(REFRESH_LATENCY - 1);
        end
      end
      REF_WAIT: begin
        if (wait_cnt == '0) state_nxt = IDLE;
        else wait_nxt = wait_cnt - 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state    <= IDLE;
      wait_cnt <= '0;
      ref_cnt  <= '0;
      pending  <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
      ref_cnt  <= wrap ? '0 : ref_cnt + 1'b1;
      // a wrap on the REF handshake edge re-arms rather than being lost
      if (wrap)
        pending <= 1'b1;
      else if (state == REF && cmd_ready_in)
        pending <= 1'b0;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      write_q        <= 1'b0;
      bank_group_out <= '0;
      bank_out       <= '0;
      row_out        <= '0;
      col_out        <= '0;
      val_out        <= '0;
    end else if (accept) begin
      write_q        <= req_write_in;
      bank_group_out <= bank_group_in;
      bank_out       <= bank_in;
      row_out        <= row_in;
      col_out        <= col_in;
      val_out        <= val_in;
    end else if (state == IDLE && pending) begin
      bank_group_out <= '0;
      bank_out       <= '0;
      row_out        <= '0;
      col_out        <= '0;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      open_q <= '0;
    end else if (done) begin
      if (state == PRE) open_q[idx_q] <= 1'b0;
      if (state == ACT) open_q[idx_q] <= 1'b1;
      if (state == REF) open_q <= '0;
    end
  end

  // row tags are only meaningful where the open bit is set
  always_ff @(posedge clk_in) begin
    if (done && state == ACT) row_tab[idx_q] <= row_out;
  end

endmodule

// File: tb/tb_dram_cmd_sequencer.sv
// Scoreboard bench for dram_cmd_sequencer: a reference model expands each
// accepted request into timed expected commands and a monitor checks them.
module tb_dram_cmd_sequencer;

  localparam int AL = 8;
  localparam int PL = 5;
  localparam int RI = 64;
  localparam int RL = 32;

  logic         clk = 1'b0;
  logic         rst_in = 1'b1;
  logic         req_valid_in = 1'b0;
  logic         req_ready_out;
  logic         req_write_in = 1'b0;
  logic [2:0]   bank_group_in = '0;
  logic [2:0]   bank_in = '0;
  logic [7:0]   row_in = '0;
  logic [3:0]   col_in = '0;
  logic [511:0] val_in = '0;
  logic         cmd_ready_in;
  logic         valid_out;
  logic [2:0]   cmd_out;
  logic [2:0]   bank_group_out;
  logic [2:0]   bank_out;
  logic [7:0]   row_out;
  logic [3:0]   col_out;
  logic [511:0] val_out;
  logic         refresh_pending_out;

  dram_cmd_sequencer #(
    .BANK_GROUPS(8), .BANKS_PER_GROUP(8), .ROW_BITS(8), .COL_BITS(4),
    .ACTIVATION_LATENCY(AL), .PRECHARGE_LATENCY(PL),
    .REFRESH_INTERVAL(RI), .REFRESH_LATENCY(RL)
  ) dut (
    .clk_in(clk), .rst_in(rst_in),
    .req_valid_in(req_valid_in), .req_ready_out(req_ready_out),
    .req_write_in(req_write_in), .bank_group_in(bank_group_in),
    .bank_in(bank_in), .row_in(row_in), .col_in(col_in),
    .val_in(val_in), .cmd_ready_in(cmd_ready_in),
    .valid_out(valid_out), .cmd_out(cmd_out),
    .bank_group_out(bank_group_out), .bank_out(bank_out),
    .row_out(row_out), .col_out(col_out), .val_out(val_out),
    .refresh_pending_out(refresh_pending_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]   cmd;
    logic [2:0]   bg;
    logic [2:0]   bk;
    logic [7:0]   row;
    logic [3:0]   col;
    logic [511:0] val;
    int           lat;
    int           due;
  } exp_t;

  exp_t q[$];
  bit          open_m [64];
  logic [7:0]  row_m [64];
  bit          owed;
  bit          clr_pend;
  int          ref_end;
  int          cyc;
  int          checks = 0;
  int          errors = 0;
  bit          rnd_ready = 1'b0;
  bit          stall_req = 1'b0;
  int          stall_done = 0;
  bit          snap_ok;
  logic [539:0] snap;

  task automatic chk(input string nm, input logic [511:0] a,
                     input logic [511:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %0h exp %0h at cyc %0d", nm, a, e, cyc);
    end
  endtask

  always @(posedge clk or posedge rst_in)
    if (rst_in) cyc <= 0;
    else cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    if (stall_req && stall_done < 4 && valid_out && cmd_out == 3'd1) begin
      cmd_ready_in = 1'b0;
      stall_done++;
    end else begin
      cmd_ready_in = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end

  function automatic exp_t mk(input logic [2:0] c, input logic [2:0] g,
                              input logic [2:0] b, input logic [7:0] r,
                              input logic [3:0] cl, input logic [511:0] v,
                              input int lat);
    exp_t e;
    e.cmd = c; e.bg = g; e.bk = b; e.row = r; e.col = cl; e.val = v;
    e.lat = lat; e.due = -1;
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    bit idle;
    int idx;
    if (rst_in) begin
      q.delete();
      for (int i = 0; i < 64; i++) open_m[i] = 1'b0;
      owed = 1'b0; clr_pend = 1'b0; ref_end = 0; snap_ok = 1'b0;
    end else begin
      if (cyc > 0 && cyc % RI == 0) owed = 1'b1;
      else if (clr_pend) owed = 1'b0;
      clr_pend = 1'b0;
      chk("refresh_pending", 512'(refresh_pending_out), 512'(owed));
      idle = (q.size() == 0) && (cyc >= ref_end);
      chk("req_ready", 512'(req_ready_out), 512'(idle && !owed));
      if (idle && owed) begin
        e = mk(3'd5, 3'd0, 3'd0, 8'd0, 4'd0, '0, 0);
        e.due = cyc + 1;
        q.push_back(e);
      end else if (idle && req_valid_in) begin
        idx = int'(bank_group_in) * 8 + int'(bank_in);
        if (open_m[idx] && row_m[idx] != row_in)
          q.push_back(mk(3'd4, bank_group_in, bank_in, row_in, col_in,
                         val_in, 0));
        if (!(open_m[idx] && row_m[idx] == row_in))
          q.push_back(mk(3'd1, bank_group_in, bank_in, row_in, col_in,
                         val_in, q.size() == 0 ? 0 : PL));
        q.push_back(mk(req_write_in ? 3'd3 : 3'd2, bank_group_in, bank_in,
                       row_in, col_in, val_in, q.size() == 0 ? 0 : AL));
        e = q[0]; e.due = cyc + 1; q[0] = e;
        open_m[idx] = 1'b1;
        row_m[idx] = row_in;
      end
      if (!valid_out) chk("nop_when_idle", 512'(cmd_out), 512'(0));
      if (snap_ok)
        chk("stall_stable",
            512'({valid_out, cmd_out, bank_group_out, bank_out, row_out,
                  col_out, val_out}), 512'(snap));
      snap_ok = 1'b0;
      if (q.size() == 0) begin
        chk("valid_unexpected", 512'(valid_out), 512'(0));
      end else begin
        e = q[0];
        chk("valid_timing", 512'(valid_out), 512'(cyc >= e.due));
        if (valid_out && cyc >= e.due) begin
          if (cyc == e.due) begin
            chk("cmd", 512'(cmd_out), 512'(e.cmd));
            chk("addr", 512'({bank_group_out, bank_out, row_out, col_out}),
                512'({e.bg, e.bk, e.row, e.col}));
            if (e.cmd == 3'd3) chk("wdata", val_out, e.val);
          end
          if (cmd_ready_in) begin
            void'(q.pop_front());
            if (e.cmd == 3'd5) begin
              ref_end = cyc + 1 + RL;
              clr_pend = 1'b1;
              for (int i = 0; i < 64; i++) open_m[i] = 1'b0;
            end
            if (q.size() != 0) begin
              e = q[0]; e.due = cyc + 1 + e.lat; q[0] = e;
            end
          end else begin
            snap = {1'b1, cmd_out, bank_group_out, bank_out, row_out,
                    col_out, val_out};
            snap_ok = 1'b1;
          end
        end
      end
    end
  end

  task automatic do_req(input bit w, input int g, input int b, input int r,
                        input int c, input logic [511:0] v);
    int n;
    @(posedge clk); #1;
    req_write_in = w; bank_group_in = 3'(g); bank_in = 3'(b);
    row_in = 8'(r); col_in = 4'(c); val_in = v;
    req_valid_in = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!req_ready_out && n < 2000);
    if (n >= 2000) chk("accept_timeout", 512'(0), 512'(1));
    @(posedge clk); #1;
    req_valid_in = 1'b0;
  endtask

  function automatic logic [511:0] rnd_val();
    logic [511:0] v;
    for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL global_timeout");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1);
  end

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_valid", 512'(valid_out), 512'(0));
    chk("reset_vals", 512'({cmd_out, row_out, val_out[7:0]}), 512'(0));
    rst_in = 1'b0;
    do_req(1'b1, 3, 2, 'h55, 'hA, 512'hA5A5A5A5A5A5A5A5);
    do_req(1'b0, 3, 2, 'h55, 'h1, rnd_val());
    do_req(1'b0, 3, 2, 'h0F, 'h8, rnd_val());
    stall_req = 1'b1;
    do_req(1'b1, 1, 1, 'h22, 'h3, rnd_val());
    n = 0;
    while (!refresh_pending_out && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("refresh_seen", 512'(refresh_pending_out), 512'(1));
    do_req(1'b0, 3, 2, 'h0F, 'h2, rnd_val());
    do_req(1'b0, 3, 2, 'h33, 'h0, rnd_val());
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(valid_out && cmd_out == 3'd4 && cmd_ready_in) && n < 300);
    chk("pre_seen", 512'(cmd_out), 512'(4));
    @(posedge clk);
    @(posedge clk); #1;
    rst_in = 1'b1;
    #1;
    chk("rst_valid", 512'(valid_out), 512'(0));
    chk("rst_cmd", 512'(cmd_out), 512'(0));
    chk("rst_ready", 512'(req_ready_out), 512'(1));
    repeat (2) @(posedge clk);
    #1;
    rst_in = 1'b0;
    do_req(1'b0, 3, 2, 'h33, 'h4, rnd_val());
    rnd_ready = 1'b1;
    for (int k = 0; k < 150; k++)
      do_req(1'($urandom_range(0, 1)), $urandom_range(0, 1),
             $urandom_range(0, 1), $urandom_range(0, 3),
             $urandom_range(0, 15), rnd_val());
    n = 0;
    while (q.size() != 0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 512'(q.size()), 512'(0));
    repeat (5) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
